// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
//
// Turns field-level instruction requests from the host program loader into
// 16-bit instruction words for the core's decoder. It writes them in sequence
// into program memory through a valid/ready write port. Accepted words go
// through a small FIFO, so the loader can run ahead of memory back-pressure.
//
// Session flow: IDLE/DONE/ERROR --start--> ENCODE --RET--> DRAIN --> DONE
//               ENCODE --invalid request--> ERROR (buffered words still drain)
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start, base_addr    begin a load session at base_addr (IDLE/DONE/ERROR)
//   in_valid/in_ready   request handshake
//   in_opcode..in_act_func  instruction fields
//   mem_write_*         program memory write port (head of FIFO)
//   busy                ENCODE or DRAIN
//   done, error         session status levels
//   error_code          01 illegal opcode, 10 ACT conflict, 11 address overflow
//   instr_count         words written to memory in this session
// -----------------------------------------------------------------------------
module instruction_encoder #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_DEPTH         = 256,
  parameter int FIFO_DEPTH            = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] base_addr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [3:0]                       in_opcode,
  input  logic [3:0]                       in_rd,
  input  logic [3:0]                       in_rs,
  input  logic [3:0]                       in_rt,
  input  logic [2:0]                       in_nzp,
  input  logic [7:0]                       in_immediate,
  input  logic [1:0]                       in_act_func,
  output logic                             mem_write_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_write_address,
  output logic [15:0]                      mem_write_data,
  input  logic                             mem_write_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       error_code,
  output logic [PROGRAM_MEM_ADDR_BITS:0]   instr_count
);

  localparam int AW    = PROGRAM_MEM_ADDR_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // The address counter needs one extra bit so it can reach PROGRAM_DEPTH.
  localparam int AC_W  = AW + 1;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_BR    = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_LDR   = 4'h7;
  localparam logic [3:0] OP_STR   = 4'h8;
  localparam logic [3:0] OP_CONST = 4'h9;
  localparam logic [3:0] OP_FMA   = 4'hA;
  localparam logic [3:0] OP_ACT   = 4'hB;
  localparam logic [3:0] OP_RET   = 4'hF;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_ACT    = 2'b10;
  localparam logic [1:0] ERR_ADDR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENCODE,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } entry_t;

  state_t              state;
  logic [AC_W-1:0]     addr_cnt;
  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;

  logic                fifo_full;
  logic                accept;
  logic                push;
  logic                pop;
  logic [15:0]         enc_word;
  logic [1:0]          check_code;
  entry_t              head;

  assign fifo_full       = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign mem_write_valid = (fifo_count != '0);
  assign pop             = mem_write_valid && mem_write_ready;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
  assign in_ready = (state == S_ENCODE) && (!fifo_full || pop);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (check_code == ERR_NONE);

  assign busy = (state == S_ENCODE) || (state == S_DRAIN);

  // Gating by valid keeps the port at zero while the FIFO is empty, because the
  // storage itself is never cleared.
  assign head              = fifo_mem[rd_ptr];
  assign mem_write_address = mem_write_valid ? head.addr : '0;
  assign mem_write_data    = mem_write_valid ? head.data : '0;

  // Field packing; fields unused by an opcode are simply not routed.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    enc_word = 16'h0000;
    case (in_opcode)
      OP_NOP:   enc_word = 16'h0000;
      OP_BR:    enc_word = {OP_BR, in_nzp, 1'b0, in_immediate};
      OP_CMP:   enc_word = {OP_CMP, 4'h0, in_rs, in_rt};
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_FMA:
                enc_word = {in_opcode, in_rd, in_rs, in_rt};
      OP_LDR:   enc_word = {OP_LDR, in_rd, in_rs, 4'h0};
      OP_STR:   enc_word = {OP_STR, 4'h0, in_rs, in_rt};
      OP_CONST: enc_word = {OP_CONST, in_rd, in_immediate};
      OP_ACT:   enc_word = {OP_ACT, in_rd[3:2], in_act_func, in_rs, in_rt};
      OP_RET:   enc_word = 16'hF000;
      default:  enc_word = 16'h0000;
    endcase
  end

  // Validation in priority order: opcode, ACT field conflict, address overflow.
  always_comb begin
    check_code = ERR_NONE;
    if (in_opcode inside {4'hC, 4'hD, 4'hE}) begin
      check_code = ERR_OPCODE;
    end else if ((in_opcode == OP_ACT) && (in_rd[1:0] != in_act_func)) begin
      check_code = ERR_ACT;
    end else if (addr_cnt == AC_W'(PROGRAM_DEPTH)) begin
      check_code = ERR_ADDR;
    end
  end

  // NOTE: the FIFO storage has no reset; fifo_count decides what is valid, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: addr_cnt[AW-1:0], data: enc_word};
    end
  end

  // NOTE: sequential state uses non-blocking assignments; a later assignment in this block overrides an earlier one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
      instr_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        addr_cnt <= addr_cnt + AC_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        instr_count <= instr_count + (AW+1)'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          // A new session discards whatever an aborted one left buffered.
          if (start) begin
            state       <= S_ENCODE;
            addr_cnt    <= {1'b0, base_addr};
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= ERR_NONE;
            instr_count <= '0;
          end
        end
        S_ENCODE: begin
          if (accept) begin
            if (check_code != ERR_NONE) begin
              state      <= S_ERROR;
              error      <= 1'b1;
              error_code <= check_code;
            end else if (in_opcode == OP_RET) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_count == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder
//
// Scenario tasks drive load sessions. Each expected memory write is pushed to
// a scoreboard queue when its request is driven. A negedge monitor pops that
// queue whenever a write handshake is about to complete.
// -----------------------------------------------------------------------------
module tb_instruction_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [3:0]    in_rd;
  logic [3:0]    in_rs;
  logic [3:0]    in_rt;
  logic [2:0]    in_nzp;
  logic [7:0]    in_immediate;
  logic [1:0]    in_act_func;
  logic          mem_write_valid;
  logic [AW-1:0] mem_write_address;
  logic [15:0]   mem_write_data;
  logic          mem_write_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    error_code;
  logic [AW:0]   instr_count;

  int n_checks    = 0;
  int n_fail      = 0;
  int write_count = 0;
  int cycle       = 0;

  logic [AW+15:0] sb [$];
  logic [AW+15:0] exp_w;

  instruction_encoder #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_DEPTH        (256),
    .FIFO_DEPTH           (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_opcode        (in_opcode),
    .in_rd            (in_rd),
    .in_rs            (in_rs),
    .in_rt            (in_rt),
    .in_nzp           (in_nzp),
    .in_immediate     (in_immediate),
    .in_act_func      (in_act_func),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .error_code       (error_code),
    .instr_count      (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // A handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (mem_write_valid === 1'b1 && mem_write_ready === 1'b1) begin
      write_count++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%h, required no write",
                 mem_write_address, mem_write_data);
      end else begin
        exp_w = sb.pop_front();
        if ({mem_write_address, mem_write_data} !== exp_w) begin
          n_fail++;
          $display("FAIL write_order: got addr=%0h data=%h, required addr=%0h data=%h",
                   mem_write_address, mem_write_data, exp_w[AW+15:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic start_session(input logic [AW-1:0] b);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Presents one request until the encoder takes it (bounded), then drops valid.
  task automatic send(input string name, input logic [3:0] op, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rt, input logic [2:0] nzp,
                      input logic [7:0] imm, input logic [1:0] af);
    logic acc;
    acc          = 1'b0;
    in_valid     = 1'b1;
    in_opcode    = op;
    in_rd        = rd;
    in_rs        = rs;
    in_rt        = rt;
    in_nzp       = nzp;
    in_immediate = imm;
    in_act_func  = af;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: got in_ready never high, required acceptance", name);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({in_ready, mem_write_valid, mem_write_address, mem_write_data, busy, done,
         error, error_code, instr_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b v=%b a=%h d=%h busy=%b done=%b err=%b code=%b cnt=%0d, required all 0",
               in_ready, mem_write_valid, mem_write_address, mem_write_data, busy, done,
               error, error_code, instr_count);
    end
  endtask

  task automatic test_basic();
    mem_write_ready = 1'b1;
    start_session(8'd0);
    sb.push_back({8'd0, 16'h3312}); send("add",   4'h3, 4'd3, 4'd1, 4'd2, 3'b000, 8'h00, 2'b00);
    sb.push_back({8'd1, 16'h9480}); send("const", 4'h9, 4'd4, 4'd0, 4'd0, 3'b000, 8'h80, 2'b00);
    sb.push_back({8'd2, 16'hF000}); send("ret",   4'hF, 4'd0, 4'd0, 4'd0, 3'b000, 8'h00, 2'b00);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: got %b, required 1", done);
    end
    n_checks++;
    if (instr_count !== 9'd3) begin
      n_fail++; $display("FAIL basic_count: got %0d, required 3", instr_count);
    end
    n_checks++;
    if ({busy, error} !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle: got busy=%b error=%b, required 0 0", busy, error);
    end
  endtask

  task automatic test_act_conflict();
    start_session(8'd0);
    sb.push_back({8'd0, 16'h1405}); send("br",   4'h1, 4'd0, 4'd0, 4'd0, 3'b010, 8'h05, 2'b00);
    sb.push_back({8'd1, 16'hB567}); send("act",  4'hB, 4'd5, 4'd6, 4'd7, 3'b000, 8'h00, 2'b01);
    send("act_bad", 4'hB, 4'd5, 4'd6, 4'd7, 3'b000, 8'h00, 2'b10);
    for (int i = 0; i < 100 && error !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if ({error, error_code} !== 3'b1_10) begin
      n_fail++; $display("FAIL act_error: got error=%b code=%b, required 1 10", error, error_code);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (instr_count !== 9'd2) begin
      n_fail++; $display("FAIL act_count: got %0d, required 2", instr_count);
    end
  endtask

  task automatic test_illegal_opcode();
    start_session(8'd0);
    sb.push_back({8'd0, 16'h0000}); send("nop", 4'h0, 4'd7, 4'd7, 4'd7, 3'b111, 8'hFF, 2'b11);
    send("op_c", 4'hC, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 2'b00);
    for (int i = 0; i < 100 && error !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if ({error, error_code, in_ready} !== 4'b1_01_0) begin
      n_fail++; $display("FAIL illegal_error: got error=%b code=%b rdy=%b, required 1 01 0",
                         error, error_code, in_ready);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if ({instr_count, mem_write_valid} !== {9'd1, 1'b0}) begin
      n_fail++; $display("FAIL illegal_count: got cnt=%0d valid=%b, required 1 0",
                         instr_count, mem_write_valid);
    end
  endtask

  task automatic test_backpressure();
    mem_write_ready = 1'b0;
    start_session(8'h10);
    sb.push_back({8'h10, 16'h3123});
    sb.push_back({8'h11, 16'h4456});
    sb.push_back({8'h12, 16'h5789});
    fork
      begin
        send("bp_add", 4'h3, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 2'b00);
        send("bp_sub", 4'h4, 4'd4, 4'd5, 4'd6, 3'b000, 8'h00, 2'b00);
        send("bp_mul", 4'h5, 4'd7, 4'd8, 4'd9, 3'b000, 8'h00, 2'b00);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_checks++;
          if ({in_ready, mem_write_valid, mem_write_address, mem_write_data} !==
              {1'b0, 1'b1, 8'h10, 16'h3123}) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b v=%b a=%h d=%h, required 0 1 10 3123",
                     in_ready, mem_write_valid, mem_write_address, mem_write_data);
          end
        end
        @(posedge clk); #1;
        mem_write_ready = 1'b1;
      end
    join
    sb.push_back({8'h13, 16'hF000}); send("bp_ret", 4'hF, 4'd0, 4'd0, 4'd0, 3'b000, 8'h00, 2'b00);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if ({done, instr_count} !== {1'b1, 9'd4}) begin
      n_fail++; $display("FAIL bp_done: got done=%b cnt=%0d, required 1 4", done, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    mem_write_ready = 1'b1;
    start_session(8'h40);
    t0 = cycle;
    sb.push_back({8'h40, 16'h7340}); send("ldr", 4'h7, 4'd3, 4'd4, 4'hF, 3'b101, 8'hAA, 2'b00);
    sb.push_back({8'h41, 16'h8056}); send("str", 4'h8, 4'hF, 4'd5, 4'd6, 3'b000, 8'h00, 2'b00);
    sb.push_back({8'h42, 16'h2012}); send("cmp", 4'h2, 4'd9, 4'd1, 4'd2, 3'b000, 8'h00, 2'b00);
    sb.push_back({8'h43, 16'hA123}); send("fma", 4'hA, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 2'b00);
    sb.push_back({8'h44, 16'hF000}); send("b2b_ret", 4'hF, 4'd0, 4'd0, 4'd0, 3'b000, 8'h00, 2'b00);
    n_checks++;
    if (cycle - t0 !== 5) begin
      n_fail++; $display("FAIL b2b_rate: got %0d cycles for 5 words, required 5", cycle - t0);
    end
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if ({done, instr_count} !== {1'b1, 9'd5}) begin
      n_fail++; $display("FAIL b2b_done: got done=%b cnt=%0d, required 1 5", done, instr_count);
    end
  endtask

  task automatic test_overflow();
    mem_write_ready = 1'b1;
    start_session(8'd254);
    sb.push_back({8'd254, 16'h3111}); send("ov_add0", 4'h3, 4'd1, 4'd1, 4'd1, 3'b000, 8'h00, 2'b00);
    sb.push_back({8'd255, 16'h4222}); send("ov_sub",  4'h4, 4'd2, 4'd2, 4'd2, 3'b000, 8'h00, 2'b00);
    send("ov_add1", 4'h3, 4'd3, 4'd3, 4'd3, 3'b000, 8'h00, 2'b00);
    for (int i = 0; i < 100 && error !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if ({error, error_code} !== 3'b1_11) begin
      n_fail++; $display("FAIL ov_error: got error=%b code=%b, required 1 11", error, error_code);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (instr_count !== 9'd2) begin
      n_fail++; $display("FAIL ov_count: got %0d, required 2", instr_count);
    end
  endtask

  task automatic test_reset_mid_session();
    int w0;
    mem_write_ready = 1'b0;
    start_session(8'd0);
    // These two are abandoned by the reset, so they are not on the scoreboard.
    send("rst_a", 4'h3, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 2'b00);
    send("rst_b", 4'h3, 4'd4, 4'd5, 4'd6, 3'b000, 8'h00, 2'b00);
    n_checks++;
    if (mem_write_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_buffered: got valid=%b, required 1", mem_write_valid);
    end
    w0 = write_count;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_write_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, mem_write_valid, mem_write_address, mem_write_data, busy, done,
         error, error_code, instr_count} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got rdy=%b v=%b a=%h d=%h busy=%b done=%b err=%b code=%b cnt=%0d, required all 0",
               in_ready, mem_write_valid, mem_write_address, mem_write_data, busy, done,
               error, error_code, instr_count);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (write_count !== w0) begin
      n_fail++; $display("FAIL rst_no_write: got %0d writes, required 0", write_count - w0);
    end
    start_session(8'd5);
    sb.push_back({8'd5, 16'h9211}); send("rst_const", 4'h9, 4'd2, 4'd0, 4'd0, 3'b000, 8'h11, 2'b00);
    sb.push_back({8'd6, 16'hF000}); send("rst_ret",   4'hF, 4'd0, 4'd0, 4'd0, 3'b000, 8'h00, 2'b00);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if ({done, instr_count} !== {1'b1, 9'd2}) begin
      n_fail++; $display("FAIL rst_restart: got done=%b cnt=%0d, required 1 2", done, instr_count);
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    base_addr       = '0;
    in_valid        = 1'b0;
    in_opcode       = '0;
    in_rd           = '0;
    in_rs           = '0;
    in_rt           = '0;
    in_nzp          = '0;
    in_immediate    = '0;
    in_act_func     = '0;
    mem_write_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_basic();
    test_act_conflict();
    test_illegal_opcode();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_session();

    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
